// File: rtl/player_move_ctrl.sv
// -----------------------------------------------------------------------------
// player_move_ctrl
// Maze player movement controller. A debounced button pulse starts a move:
// the controller fetches the wall nibble of the current cell from a shared
// maze store (req/ack handshake), checks walls and grid edges, then updates
// the player position and the accepted-move counter. Reaching the goal cell
// freezes the game until the next start pulse.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   start                        begin / restart a game (any state)
//   btn_up/down/left/right       one-cycle move pulses, priority up>down>left>right
//   cell_rd_req/row/col          maze store read request and cell address
//   cell_rd_ack, cell_rd_data    store ack and wall nibble {N,E,S,W}
//   player_row, player_col       current player cell
//   busy                         fetch or check in progress
//   blocked                      one-cycle pulse after a rejected move
//   win                          player is on the goal cell
//   move_count                   accepted moves since start, saturating
// -----------------------------------------------------------------------------
module player_move_ctrl #(
    parameter int unsigned GRID_DIM  = 15,
    parameter int unsigned START_ROW = 0,
    parameter int unsigned START_COL = 0,
    parameter int unsigned GOAL_ROW  = 14,
    parameter int unsigned GOAL_COL  = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       cell_rd_req,
    output logic [3:0] cell_rd_row,
    output logic [3:0] cell_rd_col,
    input  logic       cell_rd_ack,
    input  logic [3:0] cell_rd_data,
    output logic [3:0] player_row,
    output logic [3:0] player_col,
    output logic       busy,
    output logic       blocked,
    output logic       win,
    output logic [9:0] move_count
);

    localparam int unsigned POS_W = 4;
    localparam int unsigned CNT_W = 10;

    localparam logic [POS_W-1:0] LAST_IDX   = POS_W'(GRID_DIM - 1);
    localparam logic [POS_W-1:0] START_R    = POS_W'(START_ROW);
    localparam logic [POS_W-1:0] START_C    = POS_W'(START_COL);
    localparam logic [POS_W-1:0] GOAL_R     = POS_W'(GOAL_ROW);
    localparam logic [POS_W-1:0] GOAL_C     = POS_W'(GOAL_COL);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // Wall nibble bit positions {N,E,S,W}
    localparam int unsigned WALL_N = 3;
    localparam int unsigned WALL_E = 2;
    localparam int unsigned WALL_S = 1;
    localparam int unsigned WALL_W = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_FETCH,
        S_CHECK,
        S_WON
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    state_t             state_q,      state_d;
    dir_t               dir_q,        dir_d;
    logic [3:0]         wall_q,       wall_d;
    logic [POS_W-1:0]   row_q,        row_d;
    logic [POS_W-1:0]   col_q,        col_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    logic               req_q,        req_d;
    logic [POS_W-1:0]   rd_row_q,     rd_row_d;
    logic [POS_W-1:0]   rd_col_q,     rd_col_d;
    logic               busy_q,       busy_d;
    logic               blocked_q,    blocked_d;
    logic               win_q,        win_d;

    // Move evaluation for the latched direction against the latched walls
    logic               move_ok;
    logic [POS_W-1:0]   tgt_row;
    logic [POS_W-1:0]   tgt_col;

    logic               any_btn;
    dir_t               btn_dir;

    // Fixed-priority pick among simultaneous button pulses
    always_comb begin
        any_btn = btn_up | btn_down | btn_left | btn_right;
        btn_dir = DIR_RIGHT;
        if (btn_up) begin
            btn_dir = DIR_UP;
        end else if (btn_down) begin
            btn_dir = DIR_DOWN;
        end else if (btn_left) begin
            btn_dir = DIR_LEFT;
        end
    end

    // Legality: wall bit clear and target cell inside the grid
    always_comb begin
        move_ok = 1'b0;
        tgt_row = row_q;
        tgt_col = col_q;
        unique case (dir_q)
            DIR_UP: begin
                move_ok = !wall_q[WALL_N] && (row_q != '0);
                tgt_row = row_q - POS_W'(1);
            end
            DIR_DOWN: begin
                move_ok = !wall_q[WALL_S] && (row_q < LAST_IDX);
                tgt_row = row_q + POS_W'(1);
            end
            DIR_LEFT: begin
                move_ok = !wall_q[WALL_W] && (col_q != '0);
                tgt_col = col_q - POS_W'(1);
            end
            DIR_RIGHT: begin
                move_ok = !wall_q[WALL_E] && (col_q < LAST_IDX);
                tgt_col = col_q + POS_W'(1);
            end
            default: begin
                move_ok = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        wall_d    = wall_q;
        row_d     = row_q;
        col_d     = col_q;
        count_d   = count_q;
        req_d     = 1'b0;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        blocked_d = 1'b0;

        if (start) begin
            // start restarts the game from any state, aborting a move in flight
            state_d = S_READY;
            row_d   = START_R;
            col_d   = START_C;
            count_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_READY: begin
                    if (any_btn) begin
                        state_d  = S_FETCH;
                        dir_d    = btn_dir;
                        req_d    = 1'b1;
                        rd_row_d = row_q;
                        rd_col_d = col_q;
                    end
                end
                S_FETCH: begin
                    if (cell_rd_ack) begin
                        state_d = S_CHECK;
                        wall_d  = cell_rd_data;
                    end else begin
                        req_d = 1'b1;
                    end
                end
                S_CHECK: begin
                    if (move_ok) begin
                        row_d = tgt_row;
                        col_d = tgt_col;
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        blocked_d = 1'b1;
                    end
                    if ((row_d == GOAL_R) && (col_d == GOAL_C)) begin
                        state_d = S_WON;
                    end else begin
                        state_d = S_READY;
                    end
                end
                S_WON: begin
                    state_d = S_WON;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_CHECK);
        win_d  = (state_d == S_WON);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dir_q     <= DIR_UP;
            wall_q    <= '0;
            row_q     <= START_R;
            col_q     <= START_C;
            count_q   <= '0;
            req_q     <= 1'b0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            busy_q    <= 1'b0;
            blocked_q <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            wall_q    <= wall_d;
            row_q     <= row_d;
            col_q     <= col_d;
            count_q   <= count_d;
            req_q     <= req_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            busy_q    <= busy_d;
            blocked_q <= blocked_d;
            win_q     <= win_d;
        end
    end

    assign cell_rd_req = req_q;
    assign cell_rd_row = rd_row_q;
    assign cell_rd_col = rd_col_q;
    assign player_row  = row_q;
    assign player_col  = col_q;
    assign busy        = busy_q;
    assign blocked     = blocked_q;
    assign win         = win_q;
    assign move_count  = count_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_move_ctrl
// Self-checking bench for player_move_ctrl. A behavioural game model (grid
// position, move counter, won flag) predicts every observable output; directed
// scenarios walk the maze to the goal, then randomized moves with random walls,
// random store latency and dropped-pulse noise are checked against the model.
// -----------------------------------------------------------------------------
module tb_player_move_ctrl;

    localparam int GRID   = 15;
    localparam int GOAL_R = 14;
    localparam int GOAL_C = 14;
    localparam int SAT    = 1023;

    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       cell_rd_req;
    logic [3:0] cell_rd_row;
    logic [3:0] cell_rd_col;
    logic       cell_rd_ack = 1'b0;
    logic [3:0] cell_rd_data = 4'h0;
    logic [3:0] player_row;
    logic [3:0] player_col;
    logic       busy;
    logic       blocked;
    logic       win;
    logic [9:0] move_count;

    player_move_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .cell_rd_req  (cell_rd_req),
        .cell_rd_row  (cell_rd_row),
        .cell_rd_col  (cell_rd_col),
        .cell_rd_ack  (cell_rd_ack),
        .cell_rd_data (cell_rd_data),
        .player_row   (player_row),
        .player_col   (player_col),
        .busy         (busy),
        .blocked      (blocked),
        .win          (win),
        .move_count   (move_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Game model
    int m_row = 0;
    int m_col = 0;
    int m_cnt = 0;
    bit m_won = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic check_game(input string tag);
        check({tag, "_row"},   32'(player_row), 32'(m_row));
        check({tag, "_col"},   32'(player_col), 32'(m_col));
        check({tag, "_count"}, 32'(move_count), 32'(m_cnt));
        check({tag, "_win"},   32'(win),        32'(m_won));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_row = 0; m_col = 0; m_cnt = 0; m_won = 1'b0;
        check_game("start");
        check("start_req",  32'(cell_rd_req), 32'd0);
        check("start_busy", 32'(busy),        32'd0);
    endtask

    // One complete move: pulse, FETCH with `waits` idle cycles, ack, CHECK, result
    task automatic do_move(input logic [3:0] b, input logic [3:0] wall,
                           input int waits, input bit noise);
        int dr, dc, wbit, nr, nc;
        bit legal;
        dr = 0; dc = 0;
        if (b[3])      begin dr = -1; wbit = 3; end
        else if (b[2]) begin dr =  1; wbit = 1; end
        else if (b[1]) begin dc = -1; wbit = 0; end
        else           begin dc =  1; wbit = 2; end
        nr = m_row + dr;
        nc = m_col + dc;
        legal = (wall[wbit] == 1'b0) && nr >= 0 && nr < GRID && nc >= 0 && nc < GRID;

        @(negedge clk);
        set_btn(b);
        @(negedge clk);
        set_btn(4'h0);
        check("fetch_req",  32'(cell_rd_req), 32'd1);
        check("fetch_busy", 32'(busy),        32'd1);
        check("fetch_row",  32'(cell_rd_row), 32'(m_row));
        check("fetch_col",  32'(cell_rd_col), 32'(m_col));
        for (int i = 0; i < waits; i++) begin
            if (noise) set_btn(4'($urandom));
            @(negedge clk);
            set_btn(4'h0);
            check("hold_req", 32'(cell_rd_req), 32'd1);
            check("hold_row", 32'(cell_rd_row), 32'(m_row));
            check("hold_col", 32'(cell_rd_col), 32'(m_col));
        end
        cell_rd_ack  = 1'b1;
        cell_rd_data = wall;
        if (noise) set_btn(4'($urandom));
        @(negedge clk);
        cell_rd_ack  = 1'b0;
        cell_rd_data = 4'($urandom);
        if (noise) set_btn(4'($urandom));
        else set_btn(4'h0);
        check("check_req",  32'(cell_rd_req), 32'd0);
        check("check_busy", 32'(busy),        32'd1);
        check("check_row",  32'(player_row),  32'(m_row));
        check("check_col",  32'(player_col),  32'(m_col));
        @(negedge clk);
        set_btn(4'h0);
        if (legal) begin
            m_row = nr;
            m_col = nc;
            if (m_cnt < SAT) m_cnt++;
        end
        m_won = (m_row == GOAL_R) && (m_col == GOAL_C);
        check_game("move");
        check("move_blocked", 32'(blocked), 32'(!legal));
        check("move_busy",    32'(busy),    32'd0);
        check("move_req",     32'(cell_rd_req), 32'd0);
        // A stray ack outside FETCH must have no effect
        if (noise) begin
            cell_rd_ack  = 1'b1;
            cell_rd_data = 4'($urandom);
        end
        @(negedge clk);
        cell_rd_ack = 1'b0;
        check("after_blocked", 32'(blocked),     32'd0);
        check("after_req",     32'(cell_rd_req), 32'd0);
        check_game("after");
    endtask

    task automatic repeat_move(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) do_move(b, 4'h0, 0, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",     32'(cell_rd_req), 32'd0);
        check("rst_rd_row",  32'(cell_rd_row), 32'd0);
        check("rst_rd_col",  32'(cell_rd_col), 32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_blocked", 32'(blocked),     32'd0);
        check_game("rst");
        reset = 1'b0;

        // IDLE ignores buttons
        @(negedge clk);
        set_btn(4'hF);
        @(negedge clk);
        set_btn(4'h0);
        @(negedge clk);
        check("idle_req", 32'(cell_rd_req), 32'd0);

        // Right move with two store wait cycles
        do_start();
        do_move(B_RIGHT, 4'b0000, 2, 1'b0);

        // Up at the top edge: handshake still happens, move rejected
        do_start();
        do_move(B_UP, 4'b0000, 1, 1'b0);

        // Walk to (3,3), then down into a south wall
        repeat_move(B_DOWN, 3);
        repeat_move(B_RIGHT, 3);
        do_move(B_DOWN, 4'b0010, 0, 1'b0);

        // Walk to (5,5), then up+left together: up wins
        repeat_move(B_DOWN, 2);
        repeat_move(B_RIGHT, 2);
        do_move(B_UP | B_LEFT, 4'b0000, 0, 1'b0);
        check("prio_row", 32'(player_row), 32'd4);
        check("prio_col", 32'(player_col), 32'd5);

        // Walk to (14,13), then right onto the goal
        repeat_move(B_DOWN, 10);
        repeat_move(B_RIGHT, 8);
        do_move(B_RIGHT, 4'b0000, 1, 1'b0);
        check("goal_win", 32'(win), 32'd1);

        // WON freezes the game; buttons and acks do nothing
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_btn(4'($urandom_range(1, 15)));
            cell_rd_ack = 1'b1;
            @(negedge clk);
            set_btn(4'h0);
            cell_rd_ack = 1'b0;
            check("won_req", 32'(cell_rd_req), 32'd0);
            check_game("won");
        end
        do_start();

        // start during FETCH aborts the move
        do_move(B_RIGHT, 4'b0000, 0, 1'b0);
        @(negedge clk);
        set_btn(B_DOWN);
        @(negedge clk);
        set_btn(4'h0);
        check("abort_fetch_req", 32'(cell_rd_req), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cell_rd_ack = 1'b1;
        m_row = 0; m_col = 0; m_cnt = 0; m_won = 1'b0;
        check("abort_req",  32'(cell_rd_req), 32'd0);
        check("abort_busy", 32'(busy),        32'd0);
        check_game("abort");
        @(negedge clk);
        cell_rd_ack = 1'b0;
        check("abort_ack_req", 32'(cell_rd_req), 32'd0);
        check_game("abort_ack");
        do_move(B_DOWN, 4'b0000, 1, 1'b0);

        // Reset asserted mid-FETCH, late ack after release
        @(negedge clk);
        set_btn(B_RIGHT);
        @(negedge clk);
        set_btn(4'h0);
        check("rstf_req_pre", 32'(cell_rd_req), 32'd1);
        reset = 1'b1;
        #1;
        check("rstf_req_now", 32'(cell_rd_req), 32'd0);
        check("rstf_busy",    32'(busy),        32'd0);
        @(negedge clk);
        reset = 1'b0;
        cell_rd_ack  = 1'b1;
        cell_rd_data = 4'h0;
        set_btn(B_RIGHT);
        @(negedge clk);
        cell_rd_ack = 1'b0;
        set_btn(4'h0);
        m_row = 0; m_col = 0; m_cnt = 0; m_won = 1'b0;
        check("rstf_ack_req",  32'(cell_rd_req), 32'd0);
        check("rstf_ack_busy", 32'(busy),        32'd0);
        check_game("rstf");
        @(negedge clk);
        check("rstf_idle_req", 32'(cell_rd_req), 32'd0);
        check_game("rstf_idle");

        // Randomized moves with random walls, latency and noise
        do_start();
        for (int i = 0; i < 200; i++) begin
            logic [3:0] b, w;
            b = 4'($urandom_range(1, 15));
            w = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            do_move(b, w, $urandom_range(0, 3), 1'b1);
            if (m_won) do_start();
        end

        // Counter saturation: shuttle right/left along row 0
        do_start();
        for (int i = 0; i < 1030; i++) begin
            do_move((i % 2 == 0) ? B_RIGHT : B_LEFT, 4'h0, 0, 1'b0);
        end
        check("sat_count", 32'(move_count), 32'(SAT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  GRID_DIM  15  maze side length in cells; valid row/col 0..GRID_DIM-1
  START_ROW  0  player row after reset or restart
  START_COL  0  player column after reset or restart
  GOAL_ROW  14  goal cell row
  GOAL_COL  14  goal cell column
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk  input  1  system clock; all state rises on posedge
  reset  input  1  asynchronous, active-high reset
  start  input  1  one-cycle pulse; begin or restart a game
  btn_up / btn_down / btn_left / btn_right  input  1 each  one-cycle debounced move pulses
  cell_rd_req  output  1  maze cell read request to the shared maze store
  cell_rd_row  output  4  row of requested cell
  cell_rd_col  output  4  column of requested cell
  cell_rd_ack  input  1  store has placed the cell on cell_rd_data this cycle
  cell_rd_data  input  4  wall nibble {N,E,S,W}; 1 = wall present
  player_row  output  4  current player row
  player_col  output  4  current player column
  busy  output  1  high in FETCH and CHECK
  blocked  output  1  one-cycle pulse: the last move was rejected
  win  output  1  high while in WON
  move_count  output  10  accepted moves since the last start

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, READY, FETCH, CHECK, WON.
REQ-004 IDLE: all buttons ignored; start -> READY, player = (START_ROW, START_COL), move_count = 0.
REQ-005 READY: any button pulse -> latch direction and go to FETCH next cycle; with no pulse, remain in READY.
REQ-006 Simultaneous button pulses SHALL be resolved by fixed priority up > down > left > right; the lower-priority pulses are dropped.
REQ-007 Button pulses arriving in FETCH, CHECK, WON or IDLE SHALL be dropped, not queued.
REQ-008 FETCH: cell_rd_req = 1 and cell_rd_row/col = current player cell; both SHALL stay stable until the cycle in which cell_rd_ack = 1.
REQ-009 On the ack cycle, latch cell_rd_data and go to CHECK; cell_rd_req SHALL be 0 from the next cycle on.
REQ-010 cell_rd_req SHALL be 0 in every state other than FETCH; an ack outside FETCH SHALL be ignored.
REQ-011 There is no ack timeout; FETCH waits indefinitely.
REQ-012 CHECK (exactly one cycle): a move is legal iff the wall bit for the latched direction is 0 and the target stays within 0..GRID_DIM-1.
REQ-013 Wall bits map as up = N (bit 3), right = E (bit 2), down = S (bit 1), left = W (bit 0).
REQ-014 Legal move: update player_row/col at the end of CHECK, so the new value is visible the following cycle; move_count += 1, saturating at 1023.
REQ-015 Illegal move: position and move_count unchanged; blocked pulses high for the one cycle after CHECK.
REQ-016 After CHECK: if the updated position = (GOAL_ROW, GOAL_COL), go to WON, otherwise go to READY.
REQ-017 Latency from button pulse (cycle N) to updated position SHALL be 3 cycles plus store wait: FETCH at N+1; ack in cycle A >= N+1; CHECK at A+1; new position visible at A+2.
REQ-018 WON: win = 1, position and move_count frozen; start -> READY with position and counter reinitialised as in IDLE.
REQ-019 start in READY, FETCH or CHECK SHALL abort any move in flight, drop cell_rd_req the next cycle, and restart as in REQ-004.
REQ-020 An edge-of-grid rejection SHALL still perform the FETCH handshake; legality is decided only in CHECK.

Reset
REQ-021 While reset = 1 (asynchronous): state = IDLE, player_row = START_ROW, player_col = START_COL, move_count = 0, cell_rd_req = 0, cell_rd_row/col = 0, busy = 0, blocked = 0, win = 0.
REQ-022 Reset asserted during FETCH SHALL drop cell_rd_req immediately; a late ack after reset release SHALL be ignored (REQ-010).

Verification
REQ-023 Benches SHALL cover the following scenarios:
  reset, start, btn_right, ack with data 4'b0000 after 2 wait cycles -> req held 3 cycles with row/col = 0/0; player_col = 1 at ack+2; move_count = 1; blocked = 0
  at (0,0), btn_up with data 4'b0000 -> handshake completes; blocked pulses once; position (0,0); move_count = 0
  at (3,3), btn_down with data 4'b0010 -> blocked pulse; position (3,3)
  btn_up and btn_left in the same cycle at (5,5), data 0 -> player (4,5); the left pulse is lost
  at (14,13), btn_right with data 0 -> player (14,14); win = 1; further buttons do not raise req; start -> (0,0), win = 0, move_count = 0
  reset asserted mid-FETCH, then ack after release -> req = 0 at once; state IDLE; ack has no effect
